// File: rtl/hex_display_scan.sv
// hex_display_scan: time-multiplexed scanner for a common-anode hex display.
// Define HEX_DISPLAY_SCAN_LZB_EN to enable leading-zero blanking.
module hex_display_scan #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 50000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [4*DIGITS-1:0] value,
   output logic                pend,
   output logic                frame,
   output logic [3:0]          nibble,
   output logic [DIGITS-1:0]   dig_n
);

   localparam int CW = $clog2(PRESCALE);
   localparam int IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CMAX = CW'(PRESCALE - 1);
   localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

   logic [CW-1:0]       cnt;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] disp;
   logic [4*DIGITS-1:0] pval;
   logic                tick;
   logic                wrap;
   logic                blank;

   assign tick = (cnt == CMAX);
   assign wrap = tick && (idx == IMAX);

   // slot timer: PRESCALE cycles per digit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // digit index advances per slot; frame marks the wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx   <= '0;
         frame <= 1'b0;
      end else begin
         frame <= wrap;
         if (wrap) begin
            idx <= '0;
         end else if (tick) begin
            idx <= idx + IW'(1);
         end
      end
   end

   // commit uses the old pval, so a coincident load stays pending
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp <= '0;
         pval <= '0;
         pend <= 1'b0;
      end else begin
         if (wrap && pend) begin
            disp <= pval;
         end
         if (load) begin
            pval <= value;
            pend <= 1'b1;
         end else if (wrap) begin
            pend <= 1'b0;
         end
      end
   end

   // select the nibble of the current slot
   always_comb begin
      nibble = 4'h0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) begin
            nibble = disp[4*i +: 4];
         end
      end
   end

`ifdef HEX_DISPLAY_SCAN_LZB_EN
   // blank digit i when it and every higher digit are zero
   always_comb begin
      logic z;
      z     = 1'b1;
      blank = 1'b0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         z = z & (disp[4*i +: 4] == 4'h0);
         if (idx == IW'(i)) begin
            blank = z;
         end
      end
   end
`else
   assign blank = 1'b0;
`endif

   // one-hot-low enable, dark in the first cycle of each slot
   always_comb begin
      dig_n = '1;
      if ((cnt != '0) && !blank) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
               dig_n[i] = 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_hex_display_scan.sv
// tb_hex_display_scan: scoreboard bench for hex_display_scan
// with DIGITS = 4 and PRESCALE = 4.
module tb_hex_display_scan;

   localparam int D = 4;
   localparam int P = 4;

   typedef struct {
      int         cyc;
      logic [3:0] m;
      logic [3:0] dn;
      logic [3:0] nb;
      logic       pd;
      logic       fr;
      string      nm;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic        pend;
   logic        frame;
   logic [3:0]  nibble;
   logic [3:0]  dig_n;

   exp_t q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_tmo = 0;
   bit   done = 1'b0;

   int          m_cnt, m_idx;
   logic [15:0] m_disp, m_pval;
   logic        m_pend, m_frame;

   hex_display_scan #(.DIGITS(D), .PRESCALE(P)) dut (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .value  (value),
      .pend   (pend),
      .frame  (frame),
      .nibble (nibble),
      .dig_n  (dig_n)
   );

   always #5 clk = ~clk;

   task automatic m_reset();
      m_cnt = 0; m_idx = 0;
      m_disp = '0; m_pval = '0;
      m_pend = 0; m_frame = 0;
   endtask

   task automatic m_step();
      bit wr;
      if (rst) begin
         m_reset();
      end else begin
         wr = (m_cnt == P-1) && (m_idx == D-1);
         if (m_cnt == P-1) m_idx = (m_idx + 1) % D;
         m_frame = wr;
         if (wr && m_pend) begin
            m_disp = m_pval;
            m_pend = 0;
         end
         if (load) begin
            m_pval = value;
            m_pend = 1;
         end
         m_cnt = (m_cnt + 1) % P;
      end
   endtask

   function automatic logic [3:0] m_dn();
      bit bl;
      logic [15:0] hi;
      bl = 0;
      hi = m_disp >> (4*m_idx);
`ifdef HEX_DISPLAY_SCAN_LZB_EN
      bl = (m_idx >= 1) && (hi == 16'h0);
`endif
      if (m_cnt == 0 || bl) return 4'hF;
      return ~(4'b0001 << m_idx);
   endfunction

   task automatic chk(input string nm,
                      input logic [3:0] m,
                      input logic [3:0] dn,
                      input logic [3:0] nb,
                      input logic pd,
                      input logic fr);
      exp_t e;
      e.cyc = cyc; e.m = m;
      e.dn = dn; e.nb = nb;
      e.pd = pd; e.fr = fr;
      e.nm = nm;
      q.push_back(e);
   endtask

   // one clock: model follows the edge, optional async reset
   task automatic step(input bit arst);
      logic [15:0] sh;
      @(posedge clk);
      #1;
      cyc++;
      m_step();
      load = 1'b0;
      if (arst) begin
         rst = 1'b1;
         m_reset();
      end
      sh = m_disp >> (4*m_idx);
      chk("model", 4'hF, m_dn(), sh[3:0],
          m_pend, m_frame);
   endtask

   task automatic goto(input int i, input int c);
      int n;
      n = 0;
      do begin
         step(0);
         n++;
      end while (!(m_idx == i && m_cnt == c) && n < 100);
      if (n >= 100) n_tmo++;
   endtask

   // monitor: pop and compare everything due by this cycle
   initial begin
      exp_t e;
      bit   bad;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            bad = 0;
            if (e.m[3] && dig_n !== e.dn) bad = 1;
            if (e.m[2] && nibble !== e.nb) bad = 1;
            if (e.m[1] && pend !== e.pd) bad = 1;
            if (e.m[0] && frame !== e.fr) bad = 1;
            n_cmp++;
            if (bad) begin
               n_bad++;
               $display("FAIL %s cyc=%0d got dn=%b nb=%h pd=%b fr=%b want dn=%b nb=%h pd=%b fr=%b m=%b",
                        e.nm, e.cyc, dig_n, nibble, pend, frame,
                        e.dn, e.nb, e.pd, e.fr, e.m);
            end
         end
         if (done) begin
            n_cmp++;
            if (q.size() != 0 || n_tmo != 0) begin
               n_bad++;
               $display("FAIL drain left=%0d tmo=%0d want 0/0",
                        q.size(), n_tmo);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                     n_cmp, n_bad);
            $finish;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   logic [3:0] ntab [4];
   logic [3:0] dtab [4];
   logic [3:0] btab [4];
   logic [3:0] bdn  [4];

   initial begin
      ntab = '{4'hF, 4'h2, 4'hA, 4'h1};
      dtab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      btab = '{4'h0, 4'h7, 4'h0, 4'h0};
`ifdef HEX_DISPLAY_SCAN_LZB_EN
      bdn  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
`else
      bdn  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`endif
      m_reset();
      repeat (3) begin
         step(0);
         chk("rst_hold", 4'hF, 4'hF, 4'h0, 0, 0);
      end
      rst = 1'b0;
      step(0);
      chk("first_en", 4'hC, 4'b1110, 4'h0, 0, 0);
      load = 1'b1; value = 16'h1A2F;
      step(0);
      chk("pend_rise", 4'h2, 4'h0, 4'h0, 1, 0);
      goto(3, 3);
      chk("pend_hold", 4'h3, 4'h0, 4'h0, 1, 0);
      goto(0, 0);
      chk("commit", 4'hF, 4'hF, 4'hF, 0, 1);
      for (int s = 0; s < 4; s++) begin
         for (int k = 0; k < 4; k++) begin
            if (s != 0 || k != 0) step(0);
            chk("scan", 4'hD,
                (k == 0) ? 4'hF : dtab[s], ntab[s],
                0, (s == 0 && k == 0));
         end
      end
      goto(0, 0);
      chk("frame_pulse", 4'h1, 4'h0, 4'h0, 0, 1);
      load = 1'b1; value = 16'h1111;
      step(0);
      load = 1'b1; value = 16'h2222;
      step(0);
      goto(0, 0);
      chk("latest_c0", 4'h7, 4'h0, 4'h2, 0, 1);
      for (int i = 1; i < 16; i++) begin
         step(0);
         chk("latest", 4'h4, 4'h0, 4'h2, 0, 0);
         if (i == 1) begin
            load = 1'b1; value = 16'h00AB;
         end
      end
      load = 1'b1; value = 16'h00CD;
      step(0);
      chk("coinc", 4'h7, 4'h0, 4'hB, 1, 1);
      goto(1, 1);
      chk("coinc_s1", 4'hE, 4'b1101, 4'hA, 1, 0);
      goto(0, 0);
      chk("coinc_next", 4'h7, 4'h0, 4'hD, 0, 1);
      goto(1, 1);
      chk("coinc_s1b", 4'hC, 4'b1101, 4'hC, 0, 0);
      load = 1'b1; value = 16'h0070;
      goto(0, 0);
      for (int s = 0; s < 4; s++) begin
         for (int k = 0; k < 4; k++) begin
            if (s != 0 || k != 0) step(0);
            chk("blank", 4'hC,
                (k == 0) ? 4'hF : bdn[s], btab[s],
                0, 0);
         end
      end
      goto(0, 1);
      load = 1'b1; value = 16'h9999;
      goto(2, 1);
      chk("pre_rst", 4'h2, 4'h0, 4'h0, 1, 0);
      step(1);
      chk("rst_mid", 4'hF, 4'hF, 4'h0, 0, 0);
      step(0);
      step(0);
      rst = 1'b0;
      repeat (40) begin
         step(0);
         chk("post_rst", 4'h6, 4'h0, 4'h0, 0, 0);
      end
      done = 1'b1;
   end

endmodule
